fifo_drain_arbiter: RTL and testbench

//  Drains two show-ahead sample FIFOs into one shared downstream write port,

---
 rtl/fifo_drain_arbiter.sv | 84 ++++++++
 tb/tb_fifo_drain_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin, bounded-burst drain of two show-ahead FIFOs into one write port
//  i_clk, i_rst_n          clock, asynchronous active-low reset
//  i_enable                1 = new grants may start
//  i_fifo_empty/full       per-FIFO flags, bit i = FIFO i
//  i_fifo_level            {level1, level0} fill counts
//  i_fifo_rdata            {rdata1, rdata0} show-ahead head words
//  o_fifo_rdreq            pops the head word of the granted FIFO on a beat
//  o_out_valid/data/src    downstream word, qualified by i_out_ready
//  o_busy                  1 while in BURST or GAP
//  o_burst_done            1-cycle pulse during the GAP after a burst
module fifo_drain_arbiter #(
  parameter int DATA_W    = 16,
  parameter int LEVEL_W   = 9,
  parameter int THRESH    = 64,
  parameter int BURST_LEN = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [1:0]           i_fifo_empty,
  input  logic [1:0]           i_fifo_full,
  input  logic [2*LEVEL_W-1:0] i_fifo_level,
  input  logic [2*DATA_W-1:0]  i_fifo_rdata,
  output logic [1:0]           o_fifo_rdreq,
  output logic                 o_out_valid,
  output logic [DATA_W-1:0]    o_out_data,
  output logic                 o_out_src,
  input  logic                 i_out_ready,
  output logic                 o_busy,
  output logic                 o_burst_done
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  logic [1:0]    r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic [CW-1:0] r_beat_cnt;
  logic [1:0]    w_elig;
  logic          w_pick;
  logic          w_burst;
  logic          w_beat;
  logic [CW-1:0] w_cnt_nxt;
  always_comb begin
    w_elig[0]    = i_fifo_full[0] | (i_fifo_level[LEVEL_W-1:0] >= LEVEL_W'(THRESH));
    w_elig[1]    = i_fifo_full[1] | (i_fifo_level[2*LEVEL_W-1:LEVEL_W] >= LEVEL_W'(THRESH));
    // both eligible: alternate; otherwise the single eligible FIFO
    w_pick       = &w_elig ? ~r_last_grant : w_elig[1];
    w_burst      = r_state == S_BURST;
    o_out_valid  = w_burst & ~i_fifo_empty[r_grant];
    w_beat       = o_out_valid & i_out_ready;
    o_fifo_rdreq = {w_beat & r_grant, w_beat & ~r_grant};
    o_out_data   = w_burst ? (r_grant ? i_fifo_rdata[2*DATA_W-1:DATA_W] : i_fifo_rdata[DATA_W-1:0]) : '0;
    o_out_src    = r_grant;
    o_busy       = r_state != S_IDLE;
    o_burst_done = r_state == S_GAP;
    w_cnt_nxt    = r_beat_cnt + 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_enable & |w_elig) begin
          r_state      <= S_BURST;
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          r_beat_cnt   <= '0;
        end
        S_BURST: if (w_beat) begin
          r_beat_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CW'(BURST_LEN)) r_state <= S_GAP;
        end else if (i_fifo_empty[r_grant]) begin
          r_state <= S_GAP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: directed and random checks of fifo_drain_arbiter against a queue-based model
module tb_fifo_drain_arbiter;
  localparam int DW = 16;
  localparam int LW = 9;
  localparam int TH = 64;
  localparam int BL = 32;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ready = 1'b0;
  logic [1:0]    empty;
  logic [1:0]    full;
  logic [2*LW-1:0] level;
  logic [2*DW-1:0] rdata;
  logic [1:0]    rdreq;
  logic          valid;
  logic [DW-1:0] data;
  logic          src;
  logic          busy;
  logic          done;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int cap[2] = '{256, 256};
  logic [DW-1:0] seq = '0;
  int m_phase = 0;
  int m_src = 0;
  int m_prev = 1;
  int m_beats = 0;
  int obs_beats = 0;
  int obs_src = 0;
  int log_len[$];
  int log_src[$];

  fifo_drain_arbiter #(.DATA_W(DW), .LEVEL_W(LW), .THRESH(TH), .BURST_LEN(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_fifo_empty(empty), .i_fifo_full(full),
    .i_fifo_level(level), .i_fifo_rdata(rdata), .o_fifo_rdreq(rdreq), .o_out_valid(valid),
    .o_out_data(data), .o_out_src(src), .i_out_ready(ready), .o_busy(busy), .o_burst_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    empty = {q1.size() == 0, q0.size() == 0};
    full  = {q1.size() >= cap[1], q0.size() >= cap[0]};
    level = {LW'(q1.size()), LW'(q0.size())};
    rdata = '0;
    if (q0.size() != 0) rdata[DW-1:0] = q0[0];
    if (q1.size() != 0) rdata[2*DW-1:DW] = q1[0];
  endtask

  task automatic push(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      seq = seq + 16'h1;
      if (i == 1) q1.push_back(seq ^ 16'h5a00);
      else q0.push_back(seq);
    end
    drive();
  endtask

  // one clock: predict outputs from the model, compare, then advance model and FIFOs at the edge
  task automatic tick();
    bit e0, e1, ev, beat;
    logic [1:0] er, pop;
    int n;
    e0 = q0.size() >= TH || q0.size() >= cap[0];
    e1 = q1.size() >= TH || q1.size() >= cap[1];
    n  = (m_src == 1) ? q1.size() : q0.size();
    ev = rst_n && m_phase == 1 && n != 0;
    beat = ev && ready;
    er = beat ? ((m_src == 1) ? 2'b10 : 2'b01) : 2'b00;
    #2;
    chk("valid", 32'(valid), 32'(ev));
    chk("rdreq", 32'(rdreq), 32'(er));
    chk("busy", 32'(busy), 32'(rst_n && m_phase != 0));
    chk("burst_done", 32'(done), 32'(rst_n && m_phase == 2));
    chk("src", 32'(src), rst_n ? 32'(m_src) : 32'd0);
    if (ev) chk("data", 32'(data), 32'((m_src == 1) ? q1[0] : q0[0]));
    if (!rst_n) chk("data_rst", 32'(data), 32'd0);
    pop = rdreq;
    if (valid) obs_src = int'(src);
    if (pop != 2'b00) obs_beats++;
    if (done) begin
      log_len.push_back(obs_beats);
      log_src.push_back(obs_src);
      obs_beats = 0;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_src = 0; m_prev = 1; m_beats = 0; obs_beats = 0;
    end else if (m_phase == 0) begin
      if (en && (e0 || e1)) begin
        m_src = (e0 && e1) ? 1 - m_prev : (e1 ? 1 : 0);
        m_prev = m_src; m_beats = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (beat) begin
        m_beats++;
        if (m_beats == BL) m_phase = 2;
      end else if (n == 0) m_phase = 2;
    end else m_phase = 0;
    if (pop[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop[1] && q1.size() != 0) void'(q1.pop_front());
    #1;
    drive();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); drive();
    log_len.delete(); log_src.delete();
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (obs_beats < n && k < 100) begin tick(); k++; end
    chk("beat_wait_timeout", 32'(obs_beats >= n), 32'd1);
  endtask

  initial begin
    drive();
    ticks(3);
    rst_n = 1'b1;
    // reset in the middle of a burst
    push(0, 100); en = 1'b1; ready = 1'b1;
    wait_beats(5);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rdreq", 32'(rdreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    ticks(2);
    q0.delete(); push(0, 10);
    rst_n = 1'b1;
    ticks(5);
    chk("idle_after_rst", 32'(busy), 32'd0);
    // single FIFO, two back-to-back bursts
    push(0, 90);
    log_len.delete(); log_src.delete();
    ticks(80);
    chk("single_nbursts", 32'(log_len.size()), 32'd2);
    for (int k = 0; k < 2 && k < log_len.size(); k++) begin
      chk("single_len", 32'(log_len[k]), 32'(BL));
      chk("single_src", 32'(log_src[k]), 32'd0);
    end
    // both eligible from reset: strict alternation
    do_reset();
    push(0, 200); push(1, 200);
    ticks(140);
    chk("rr_nbursts", 32'(log_len.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_len.size(); k++) begin
      chk("rr_len", 32'(log_len[k]), 32'(BL));
      chk("rr_src", 32'(log_src[k]), 32'(k % 2));
    end
    // FIFO 1 eligible through full, empties after 10 words
    do_reset();
    cap[1] = 10; push(1, 10);
    ticks(20);
    chk("early_nbursts", 32'(log_len.size()), 32'd1);
    if (log_len.size() != 0) begin
      chk("early_len", 32'(log_len[0]), 32'd10);
      chk("early_src", 32'(log_src[0]), 32'd1);
    end
    cap[1] = 256;
    // backpressure 1,0,0,1
    do_reset();
    push(0, 100);
    for (int k = 0; k < 72; k++) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
    end
    chk("bp_len", log_len.size() != 0 ? 32'(log_len[0]) : 32'hffff, 32'(BL));
    ready = 1'b1;
    // enable dropped mid-burst
    do_reset();
    push(0, 200);
    wait_beats(5);
    en = 1'b0;
    ticks(40);
    chk("en0_len", log_len.size() != 0 ? 32'(log_len[0]) : 32'hffff, 32'(BL));
    chk("en0_nbursts", 32'(log_len.size()), 32'd1);
    chk("en0_idle", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    #2;
    chk("en1_restart", 32'(busy), 32'd1);
    #1;
    // randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      en = $urandom_range(0, 9) != 0;
      ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) begin
        int f;
        f = int'($urandom_range(0, 1));
        if (((f == 1) ? q1.size() : q0.size()) < 250) push(f, int'($urandom_range(0, 3)));
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
